spi_byte_engine: RTL and testbench

Hardware SPI byte shifter that replaces bit-banged SPI transfers on the expansion board. It sits downstream of the expansion top-level control decoder. That decoder turns a Gigatron extended-ctrl write into a one-cycle start strobe plus a data byte. This block then shifts the byte out on MOSI/SCK, captures MISO, and presents the received byte for the top level's read port mux. Chip selects stay in the top level; the top level feeds this block an already-selected MISO.

---
 rtl/spi_byte_engine.sv | 152 +++++++++++++++
 tb/tb_spi_byte_engine.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter: shifts TXD out on MOSI/SCK and captures MISO into RXD.
// Optional LSB-first bit order is enabled by defining SPI_LSB_FIRST_EN.
`timescale 1ns/1ps
module spi_byte_engine #(
    parameter int unsigned DIVW = 4
) (
    input  logic            CLK,
    input  logic            nRESET,
    input  logic            STB,
    input  logic [7:0]      TXD,
    input  logic [DIVW-1:0] DIV,
    input  logic            RDACK,
    input  logic            MISO,
`ifdef SPI_LSB_FIRST_EN
    input  logic            LSBF,
`endif
    output logic            SCK,
    output logic            MOSI,
    output logic [7:0]      RXD,
    output logic            BUSY,
    output logic            DONE
);

    // Completion is folded into the final HIGH->IDLE edge, so no separate done state is needed.
    typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

    state_e          state_q, state_d;
    logic            sck_q, sck_d;
    logic            mosi_q, mosi_d;
    logic            done_q, done_d;
    logic [7:0]      rxd_q, rxd_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      rx_q, rx_d;
    logic [2:0]      bit_q, bit_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic            lsbf_in;

`ifdef SPI_LSB_FIRST_EN
    logic lsbf_q, lsbf_d;
    assign lsbf_in = LSBF;
`else
    localparam logic lsbf_q = 1'b0;
    assign lsbf_in = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        done_d  = done_q;
        rxd_d   = rxd_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
`ifdef SPI_LSB_FIRST_EN
        lsbf_d  = lsbf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (RDACK) done_d = 1'b0;
                if (STB) begin
                    state_d = StLow;
                    sh_d    = TXD;
                    rx_d    = 8'h00;
                    div_d   = DIV;
                    cnt_d   = DIV;
                    bit_d   = 3'd0;
                    done_d  = 1'b0;
                    sck_d   = 1'b0;
                    mosi_d  = lsbf_in ? TXD[0] : TXD[7];
`ifdef SPI_LSB_FIRST_EN
                    lsbf_d  = LSBF;
`endif
                end
            end
            StLow: begin
                if (cnt_q == '0) begin
                    sck_d   = 1'b1;
                    cnt_d   = div_q;
                    rx_d    = lsbf_q ? {MISO, rx_q[7:1]} : {rx_q[6:0], MISO};
                    state_d = StHigh;
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end
            StHigh: begin
                if (cnt_q == '0) begin
                    sck_d = 1'b0;
                    cnt_d = div_q;
                    if (bit_q == 3'd7) begin
                        // Completion wins over a coincident RDACK.
                        rxd_d   = rx_q;
                        done_d  = 1'b1;
                        mosi_d  = 1'b1;
                        bit_d   = 3'd0;
                        state_d = StIdle;
                    end else begin
                        sh_d    = lsbf_q ? {1'b0, sh_q[7:1]} : {sh_q[6:0], 1'b0};
                        mosi_d  = lsbf_q ? sh_q[1] : sh_q[6];
                        bit_d   = bit_q + 3'd1;
                        state_d = StLow;
                    end
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q <= StIdle;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            done_q  <= 1'b0;
            rxd_q   <= 8'h00;
            sh_q    <= 8'h00;
            rx_q    <= 8'h00;
            bit_q   <= 3'd0;
            div_q   <= '0;
            cnt_q   <= '0;
`ifdef SPI_LSB_FIRST_EN
            lsbf_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            rxd_q   <= rxd_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
`ifdef SPI_LSB_FIRST_EN
            lsbf_q  <= lsbf_d;
`endif
        end
    end

    assign SCK  = sck_q;
    assign MOSI = mosi_q;
    assign RXD  = rxd_q;
    assign BUSY = (state_q != StIdle);
    assign DONE = done_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed self-checking bench for spi_byte_engine; outputs sampled on the falling CLK edge.
`timescale 1ns/1ps
module tb_spi_byte_engine;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       stb = 1'b0;
    logic [7:0] txd = 8'h00;
    logic [3:0] div = 4'd0;
    logic       rdack = 1'b0;
    logic       miso;
    logic       lsbf = 1'b0;
    logic       sck, mosi, busy, done;
    logic [7:0] rxd;
    logic       loopback = 1'b0;
    logic       miso_val = 1'b0;

    int checks = 0;
    int errors = 0;

    int         busy_n, rises, highs, done_in_busy;
    logic [7:0] seq;
    logic       first;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : miso_val;

    spi_byte_engine #(.DIVW(4)) dut (
        .CLK    (clk),
        .nRESET (nreset),
        .STB    (stb),
        .TXD    (txd),
        .DIV    (div),
        .RDACK  (rdack),
        .MISO   (miso),
`ifdef SPI_LSB_FIRST_EN
        .LSBF   (lsbf),
`endif
        .SCK    (sck),
        .MOSI   (mosi),
        .RXD    (rxd),
        .BUSY   (busy),
        .DONE   (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [7:0] exp_rxd, input logic exp_done);
        check({tag, ".sck"},  {31'd0, sck},  32'd0);
        check({tag, ".mosi"}, {31'd0, mosi}, 32'd1);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, ".rxd"},  {24'd0, rxd},  {24'd0, exp_rxd});
    endtask

    // Pulses STB, then samples once per cycle while BUSY; optional second STB / reset pulse.
    task automatic xfer(input logic [3:0] d, input logic [7:0] t, input int stb_at,
                        input int rst_at);
        logic prev;
        @(negedge clk);
        div = d;
        txd = t;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        busy_n = 0; rises = 0; highs = 0; done_in_busy = 0; seq = 8'h00;
        first = mosi;
        prev = 1'b0;
        while (busy && busy_n < 2000) begin
            busy_n++;
            if (sck && !prev) begin
                rises++;
                seq = {seq[6:0], mosi};
            end
            if (sck) highs++;
            if (done) done_in_busy++;
            prev = sck;
            stb = (busy_n == stb_at);
            if (stb) txd = 8'h3C;
            nreset = (busy_n != rst_at);
            @(negedge clk);
        end
        stb = 1'b0;
        nreset = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle("reset", 8'h00, 1'b0);
        nreset = 1'b1;
        @(negedge clk);
        check_idle("post_reset", 8'h00, 1'b0);

        // DIV=0 loopback of A5
        loopback = 1'b1;
        xfer(4'd0, 8'hA5, 0, 0);
        check("a5.first_mosi", {31'd0, first}, 32'd1);
        check("a5.busy_cycles", busy_n, 32'd16);
        check("a5.rises", rises, 32'd8);
        check("a5.mosi_seq", {24'd0, seq}, 32'hA5);
        check_idle("a5.end", 8'hA5, 1'b1);

        // DIV=3, TXD=00, MISO tied high
        loopback = 1'b0;
        miso_val = 1'b1;
        xfer(4'd3, 8'h00, 0, 0);
        check("ff.first_mosi", {31'd0, first}, 32'd0);
        check("ff.busy_cycles", busy_n, 32'd64);
        check("ff.rises", rises, 32'd8);
        check("ff.sck_high_cycles", highs, 32'd32);
        check("ff.mosi_seq", {24'd0, seq}, 32'h00);
        check_idle("ff.end", 8'hFF, 1'b1);

        // Second STB mid-transfer is ignored
        loopback = 1'b1;
        xfer(4'd2, 8'hC3, 20, 0);
        check("c3.busy_cycles", busy_n, 32'd48);
        check("c3.mosi_seq", {24'd0, seq}, 32'hC3);
        check("c3.done_during_busy", done_in_busy, 32'd0);
        repeat (3) @(negedge clk);
        check("c3.no_restart", {31'd0, busy}, 32'd0);
        check_idle("c3.end", 8'hC3, 1'b1);
        rdack = 1'b1;
        @(negedge clk);
        rdack = 1'b0;
        check_idle("c3.rdack", 8'hC3, 1'b0);

        // Reset at cycle 10 of a DIV=1 transfer
        xfer(4'd1, 8'hA5, 0, 10);
        check("rst.busy_cycles", busy_n, 32'd10);
        check_idle("rst.outputs", 8'h00, 1'b0);
        xfer(4'd1, 8'h5A, 0, 0);
        check("after_rst.busy_cycles", busy_n, 32'd32);
        check("after_rst.mosi_seq", {24'd0, seq}, 32'h5A);
        check_idle("after_rst.end", 8'h5A, 1'b1);

`ifdef SPI_LSB_FIRST_EN
        lsbf = 1'b1;
        xfer(4'd0, 8'h01, 0, 0);
        check("lsb.first_mosi", {31'd0, first}, 32'd1);
        check("lsb.mosi_seq", {24'd0, seq}, 32'h80);
        check("lsb.busy_cycles", busy_n, 32'd16);
        check_idle("lsb.end", 8'h01, 1'b1);
        lsbf = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
